// File: rtl/mii_tx_pkg.sv
// Shared types and constants for the MII transmit framer and its CRC helper.
package mii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam logic [3:0] NIB_PREAMBLE = 4'h5;
  localparam logic [3:0] NIB_SFD      = 4'hD;

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 step over one byte, LSB first.
// Shared with the receive path for FCS checking.
module crc32_byte
  import mii_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data_byte[i]) == 1'b1) ? CRC32_POLY_REFL : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_frame_tx.sv
// Ethernet MII transmit framer: preamble, SFD, payload, zero pad, FCS and IFG,
// advancing one nibble per nib_stb pulse.
module mii_frame_tx
  import mii_tx_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_FRAME_BYTES  = 60,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic        mainclk,
  input  logic        rst,
  input  logic        nib_stb,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        eth_tx_en,
  output logic [3:0]  eth_txd,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  tx_state_t   state, next_state;
  logic [7:0]  cnt;
  logic        hi;
  logic        cur_last;
  logic [3:0]  shift_hi;
  logic [31:0] crc, crc_next, fcs_word;
  logic [7:0]  crc_byte;
  logic [10:0] byte_count;
  logic [7:0]  hold_data;
  logic        hold_last, hold_full;
  logic        pad_needed;
  logic [4:0]  fcs_sel;

  logic        drv_en;
  logic [3:0]  drv_txd;
  logic        cnt_set1, cnt_inc, crc_init, load_hold, load_pad, set_hi, abort, frame_done;

  assign pad_needed = byte_count < 11'(MIN_FRAME_BYTES);
  assign fcs_word   = ~crc;
  assign fcs_sel    = {cnt[2:0], 2'b00};
  assign crc_byte   = load_pad ? 8'h00 : hold_data;
  assign busy       = (state != IDLE);
  assign in_ready   = ~hold_full & ~rst & (state inside {IDLE, PREAMBLE, SFD, DATA});

  crc32_byte u_crc (
    .crc_in    (crc),
    .data_byte (crc_byte),
    .crc_out   (crc_next)
  );

  always_ff @(posedge mainclk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (nib_stb) begin
      case (state)
        IDLE:     if (hold_full) next_state = PREAMBLE;
        PREAMBLE: if (cnt == 8'(PREAMBLE_NIBBLES)) next_state = SFD;
        SFD:      next_state = DATA;
        DATA: begin
          if (hi) begin
            if (cur_last)        next_state = pad_needed ? PAD : FCS;
            else if (!hold_full) next_state = IFG;
          end
        end
        PAD:      if (hi && !pad_needed) next_state = FCS;
        FCS:      if (cnt == 8'd8) next_state = IFG;
        IFG:      if (cnt == 8'(IFG_NIBBLES - 1)) next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Decides what the next strobe drives on the wire and which datapath updates it triggers.
  always_comb begin
    drv_en     = 1'b0;
    drv_txd    = 4'h0;
    cnt_set1   = 1'b0;
    cnt_inc    = 1'b0;
    crc_init   = 1'b0;
    load_hold  = 1'b0;
    load_pad   = 1'b0;
    set_hi     = 1'b0;
    abort      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          drv_en   = 1'b1;
          drv_txd  = NIB_PREAMBLE;
          cnt_set1 = 1'b1;
        end
      end
      PREAMBLE: begin
        drv_en = 1'b1;
        if (cnt == 8'(PREAMBLE_NIBBLES)) begin
          drv_txd  = NIB_SFD;
          crc_init = 1'b1;
        end else begin
          drv_txd = NIB_PREAMBLE;
          cnt_inc = 1'b1;
        end
      end
      SFD: begin
        drv_en    = 1'b1;
        drv_txd   = hold_data[3:0];
        load_hold = 1'b1;
      end
      DATA, PAD: begin
        if (!hi) begin
          drv_en  = 1'b1;
          drv_txd = (state == DATA) ? shift_hi : 4'h0;
          set_hi  = 1'b1;
        end else if (state == PAD || cur_last) begin
          drv_en = 1'b1;
          if (pad_needed) begin
            load_pad = 1'b1;
          end else begin
            drv_txd  = fcs_word[3:0];
            cnt_set1 = 1'b1;
          end
        end else if (hold_full) begin
          drv_en    = 1'b1;
          drv_txd   = hold_data[3:0];
          load_hold = 1'b1;
        end else begin
          abort    = 1'b1;
          cnt_set1 = 1'b1;
        end
      end
      FCS: begin
        if (cnt != 8'd8) begin
          drv_en     = 1'b1;
          drv_txd    = fcs_word[fcs_sel +: 4];
          cnt_inc    = 1'b1;
          frame_done = (cnt == 8'd7);
        end else begin
          cnt_set1 = 1'b1;
        end
      end
      IFG:     cnt_inc = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge mainclk) begin
    if (rst) begin
      eth_tx_en   <= 1'b0;
      eth_txd     <= 4'h0;
      underrun    <= 1'b0;
      frames_sent <= 16'h0;
      hold_data   <= 8'h0;
      hold_last   <= 1'b0;
      hold_full   <= 1'b0;
      cnt         <= 8'h0;
      hi          <= 1'b0;
      cur_last    <= 1'b0;
      shift_hi    <= 4'h0;
      crc         <= CRC32_INIT;
      byte_count  <= 11'h0;
    end else begin
      underrun <= 1'b0;
      if (in_valid && in_ready) begin
        hold_data <= in_data;
        hold_last <= in_last;
        hold_full <= 1'b1;
      end
      if (nib_stb) begin
        eth_tx_en <= drv_en;
        eth_txd   <= drv_txd;
        underrun  <= abort;
        if (cnt_set1)     cnt <= 8'd1;
        else if (cnt_inc) cnt <= cnt + 8'd1;
        if (crc_init) begin
          crc        <= CRC32_INIT;
          byte_count <= 11'h0;
        end
        if (set_hi) hi <= 1'b1;
        if (load_hold || load_pad) begin
          crc <= crc_next;
          hi  <= 1'b0;
          if (byte_count != 11'h7FF) byte_count <= byte_count + 11'd1;
        end
        if (load_hold) begin
          shift_hi  <= hold_data[7:4];
          cur_last  <= hold_last;
          hold_full <= 1'b0;
        end
        if (frame_done) frames_sent <= frames_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_tx.sv
// Randomised self-checking bench for mii_frame_tx against a frame-level reference model.
module tb_mii_frame_tx;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [3:0] nib_q_t[$];

  logic        mainclk;
  logic        rst;
  logic        nib_stb;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        eth_tx_en;
  logic [3:0]  eth_txd;
  logic        busy;
  logic        underrun;
  logic [15:0] frames_sent;

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  logic drv_abort;

  // Per-strobe wire log plus per-cycle counters, written only by the monitor.
  logic mon_en[$];
  logic [3:0] mon_txd[$];
  logic mon_busy[$];
  logic mon_und[$];
  int und_cycles = 0;
  int ready_in_gap = 0;
  int chg_viol = 0;
  int cur_run = 0;
  logic m_stb, m_rst, prev_en;
  logic [3:0] prev_txd;

  mii_frame_tx dut (
    .mainclk     (mainclk),
    .rst         (rst),
    .nib_stb     (nib_stb),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .eth_tx_en   (eth_tx_en),
    .eth_txd     (eth_txd),
    .busy        (busy),
    .underrun    (underrun),
    .frames_sent (frames_sent)
  );

  initial mainclk = 1'b0;
  always #5 mainclk = ~mainclk;

  initial begin
    nib_stb = 1'b0;
    forever begin
      repeat (3) @(negedge mainclk);
      nib_stb = 1'b1;
      @(negedge mainclk);
      nib_stb = 1'b0;
    end
  end

  always @(posedge mainclk) begin
    m_stb = nib_stb;
    m_rst = rst;
    #1;
    if (underrun === 1'b1) und_cycles++;
    if (eth_tx_en === 1'b0 && busy === 1'b1 && in_ready === 1'b1) ready_in_gap++;
    if (!m_stb && !m_rst && (eth_tx_en !== prev_en || eth_txd !== prev_txd)) chg_viol++;
    prev_en  = eth_tx_en;
    prev_txd = eth_txd;
    if (m_stb && !m_rst) begin
      mon_en.push_back(eth_tx_en);
      mon_txd.push_back(eth_txd);
      mon_busy.push_back(busy);
      mon_und.push_back(underrun);
      cur_run = (eth_tx_en === 1'b1) ? cur_run + 1 : 0;
    end
    if (m_rst) cur_run = 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] crcStep(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] x;
    x = r;
    for (int k = 0; k < 8; k++) begin
      if ((x[0] ^ b[k]) == 1'b1) x = (x >> 1) ^ 32'hEDB88320;
      else                       x = x >> 1;
    end
    return x;
  endfunction

  // Reference frame: preamble, SFD, payload padded to 60 bytes, then the FCS bytes, each byte low nibble first.
  task automatic buildExpected(input byte_q_t payload, output nib_q_t nibs);
    byte_q_t frame;
    logic [31:0] r;
    logic [31:0] fcs;
    frame = payload;
    while (frame.size() < 60) frame.push_back(8'h00);
    r = 32'hFFFFFFFF;
    foreach (frame[i]) r = crcStep(r, frame[i]);
    fcs = ~r;
    for (int k = 0; k < 4; k++) frame.push_back(fcs[8*k +: 8]);
    nibs = {};
    for (int k = 0; k < 15; k++) nibs.push_back(4'h5);
    nibs.push_back(4'hD);
    foreach (frame[i]) begin
      nibs.push_back(frame[i][3:0]);
      nibs.push_back(frame[i][7:4]);
    end
  endtask

  task automatic applyStimulus(input byte_q_t data, input int n_send);
    int t;
    for (int i = 0; i < n_send; i++) begin
      @(negedge mainclk);
      if (drv_abort) break;
      in_valid = 1'b1;
      in_data  = data[i];
      in_last  = (i == data.size() - 1);
      t = 0;
      while (!in_ready && !drv_abort && t < 5000) begin
        @(negedge mainclk);
        t++;
      end
      if (drv_abort) break;
      if (t >= 5000) begin
        checkOutput("ready_timeout", 32'(t), 0);
        break;
      end
      @(posedge mainclk);
    end
    @(negedge mainclk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitBusy(input logic level, input string tag);
    int t = 0;
    while (busy !== level && t < 20000) begin
      @(negedge mainclk);
      t++;
    end
    checkOutput(tag, busy, level);
  endtask

  task automatic getBurst(input int from, output nib_q_t nibs, output int stop);
    int i = from;
    nibs = {};
    while (i < mon_en.size() && mon_en[i] !== 1'b1) i++;
    while (i < mon_en.size() && mon_en[i] === 1'b1) begin
      nibs.push_back(mon_txd[i]);
      i++;
    end
    stop = i;
  endtask

  task automatic idleToBusy0(input int from, output int n);
    n = 0;
    for (int i = from; i < mon_en.size(); i++) begin
      if (mon_en[i] === 1'b1) break;
      n++;
      if (mon_busy[i] === 1'b0) break;
    end
  endtask

  task automatic checkFrame(input string tag, input byte_q_t payload, input nib_q_t nibs);
    nib_q_t want;
    int mism = 0;
    logic [31:0] r;
    buildExpected(payload, want);
    checkOutput({tag, "_len"}, nibs.size(), want.size());
    for (int i = 0; i < nibs.size() && i < want.size(); i++)
      if (nibs[i] !== want[i]) mism++;
    checkOutput({tag, "_nibs"}, mism, 0);
    r = 32'hFFFFFFFF;
    for (int i = 16; i + 1 < nibs.size(); i += 2) r = crcStep(r, {nibs[i+1], nibs[i]});
    checkOutput({tag, "_fcs"}, r, 32'hDEBB20E3);
  endtask

  task automatic runFrame(input string tag, input byte_q_t p);
    nib_q_t nibs;
    int mark, stop, n;
    mark = mon_en.size();
    applyStimulus(p, p.size());
    waitBusy(1'b1, {tag, "_start"});
    waitBusy(1'b0, {tag, "_end"});
    getBurst(mark, nibs, stop);
    checkFrame(tag, p, nibs);
    idleToBusy0(stop, n);
    checkOutput({tag, "_ifg"}, n, 24);
    exp_frames++;
    checkOutput({tag, "_frames"}, frames_sent, exp_frames);
  endtask

  function automatic byte_q_t randBytes(input int len);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  initial begin
    byte_q_t p, p2;
    nib_q_t nibs, want, nibs2;
    int mark, stop, stop2, n, u0, g0, mism, t;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h0;
    in_last = 1'b0;
    drv_abort = 1'b0;
    repeat (4) @(negedge mainclk);
    checkOutput("rst_tx_en", eth_tx_en, 0);
    checkOutput("rst_txd", eth_txd, 0);
    checkOutput("rst_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_frames", frames_sent, 0);
    rst = 1'b0;
    @(negedge mainclk);
    checkOutput("ready_idle", in_ready, 1);

    $display("[TB] single byte frame");
    p = {8'hAA};
    runFrame("aa", p);

    $display("[TB] 64 byte counting frame");
    p = {};
    for (int i = 0; i < 64; i++) p.push_back(8'(i));
    runFrame("cnt64", p);

    $display("[TB] pad boundary and random frames");
    runFrame("len59", randBytes(59));
    runFrame("len60", randBytes(60));
    runFrame("len61", randBytes(61));
    runFrame("rnd", randBytes($urandom_range(2, 80)));

    $display("[TB] underrun");
    mark = mon_en.size();
    u0 = und_cycles;
    p = randBytes(10);
    applyStimulus(p, 5);
    waitBusy(1'b1, "und_start");
    waitBusy(1'b0, "und_end");
    getBurst(mark, nibs, stop);
    checkOutput("und_len", nibs.size(), 26);
    buildExpected(p, want);
    mism = 0;
    for (int i = 0; i < nibs.size() && i < 26; i++)
      if (nibs[i] !== want[i]) mism++;
    checkOutput("und_nibs", mism, 0);
    checkOutput("und_pulses", und_cycles - u0, 1);
    checkOutput("und_at_fall", (stop < mon_und.size()) ? 32'(mon_und[stop]) : 32'hEEEE, 1);
    idleToBusy0(stop, n);
    checkOutput("und_ifg", n, 24);
    checkOutput("und_frames", frames_sent, exp_frames);

    $display("[TB] reset mid frame");
    p = randBytes(25);
    fork
      applyStimulus(p, p.size());
      begin
        t = 0;
        while (cur_run < 56 && t < 5000) begin
          @(negedge mainclk);
          t++;
        end
        checkOutput("rst_reach", cur_run, 56);
        rst = 1'b1;
        drv_abort = 1'b1;
        @(posedge mainclk);
        #1;
        checkOutput("mid_rst_tx_en", eth_tx_en, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
        checkOutput("mid_rst_frames", frames_sent, 0);
      end
    join
    repeat (3) @(negedge mainclk);
    rst = 1'b0;
    drv_abort = 1'b0;
    exp_frames = 0;
    runFrame("post_rst", randBytes(1));

    $display("[TB] back to back frames");
    g0 = ready_in_gap;
    mark = mon_en.size();
    p  = randBytes($urandom_range(1, 20));
    p2 = randBytes($urandom_range(1, 20));
    applyStimulus(p, p.size());
    applyStimulus(p2, p2.size());
    waitBusy(1'b1, "b2b_start");
    waitBusy(1'b0, "b2b_end");
    getBurst(mark, nibs, stop);
    checkFrame("b2b1", p, nibs);
    n = 0;
    for (int i = stop; i < mon_en.size() && mon_en[i] !== 1'b1; i++) n++;
    checkOutput("b2b_gap", n, 24);
    getBurst(stop, nibs2, stop2);
    checkFrame("b2b2", p2, nibs2);
    exp_frames += 2;
    checkOutput("b2b_frames", frames_sent, exp_frames);
    checkOutput("b2b_ready_in_ifg", ready_in_gap - g0, 0);

    checkOutput("ready_in_ifg_all", ready_in_gap, 0);
    checkOutput("tx_change_off_strobe", chg_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
